axi4l_reg_slave: RTL and testbench

//   AXI4-Lite responder (subordinate) terminating a bus into a bank of NUM_REGS

---
 rtl/axi4l_reg_slave.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_axi4l_reg_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi4l_reg_slave
//  Brief    : AXI4-Lite subordinate terminating a bus into NUM_REGS 32-bit
//             registers, exposed flat to fabric with per-register strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4l_reg_slave #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr,
    output logic [NUM_REGS-1:0]            reg_rd
);

    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam int         NBYTES      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axi4l_reg_slave: DATA_WIDTH must be 32");
        end
        if (NUM_REGS < 1 || NUM_REGS > (1 << IDX_W)) begin : g_bad_num_regs
            $error("axi4l_reg_slave: NUM_REGS out of range for ADDR_WIDTH");
        end
    endgenerate

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

    // Write path state
    logic [0:0]            wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;

    logic                  w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_commit, w_wr_hit;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NBYTES-1:0]     w_wr_strb;
    logic [NUM_REGS-1:0]   w_wr_sel;

    // Read path state
    logic [0:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REGS-1:0]   reg_rd_q, reg_rd_d;

    logic                  w_ar_hs, w_rd_hit;
    logic [IDX_W-1:0]      w_ar_idx;
    logic [NUM_REGS-1:0]   w_rd_sel;
    logic [DATA_WIDTH-1:0] w_rd_val;

    logic                  w_unused_ok;

    assign w_unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    // The second half of a write may arrive on the commit edge itself, so
    // address/data come from the live bus when not yet held.
    assign w_aw_hs   = awvalid & awready_q;
    assign w_w_hs    = wvalid & wready_q;
    assign w_have_aw = aw_held_q | w_aw_hs;
    assign w_have_w  = w_held_q | w_w_hs;
    assign w_commit  = (wstate_q == W_IDLE) & w_have_aw & w_have_w;
    assign w_wr_idx  = aw_held_q ? aw_idx_q : awaddr[ADDR_WIDTH-1:2];
    assign w_wr_data = w_held_q ? wdata_q : wdata;
    assign w_wr_strb = w_held_q ? wstrb_q : wstrb;
    assign w_wr_hit  = |w_wr_sel;

    assign w_ar_hs   = arvalid & arready_q;
    assign w_ar_idx  = araddr[ADDR_WIDTH-1:2];
    assign w_rd_hit  = |w_rd_sel;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
            assign w_wr_sel[i] = (w_wr_idx == IDX_W'(i));
            assign w_rd_sel[i] = (w_ar_idx == IDX_W'(i));
        end
    endgenerate

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_sel[i]) begin
                w_rd_val = regs_q[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            regs_q <= {NUM_REGS{RESET_VAL}};
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_wr_sel[i] && w_wr_strb[b]) begin
                        regs_q[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            reg_wr_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (w_commit) wstate_d = W_RESP;
            W_RESP:  if (bvalid_q && bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_wr_d  = '0;
        case (wstate_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = awaddr[ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (w_commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_wr_hit ? RESP_OKAY : RESP_DECERR;
                    reg_wr_d  = w_wr_sel;
                end else begin
                    awready_d = ~w_have_aw;
                    wready_d  = ~w_have_w;
                end
            end
            W_RESP: begin
                // Readys stay low for one extra cycle after the B handshake.
                if (bvalid_q && bready) begin
                    bvalid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------------- read FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            reg_rd_q  <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            reg_rd_q  <= reg_rd_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (w_ar_hs) rstate_d = R_DATA;
            R_DATA:  if (rvalid_q && rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        reg_rd_d  = '0;
        case (rstate_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    rvalid_d = 1'b1;
                    rdata_d  = w_rd_val;
                    rresp_d  = w_rd_hit ? RESP_OKAY : RESP_DECERR;
                    reg_rd_d = w_rd_sel;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign reg_q   = regs_q;
    assign reg_wr  = reg_wr_q;
    assign reg_rd  = reg_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4l_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4l_reg_slave
//  Brief    : Scoreboard bench for axi4l_reg_slave with a register-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4l_reg_slave;

    localparam int         AW     = 12;
    localparam int         NR     = 16;
    localparam int         TMO    = 200;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [AW-1:0]  awaddr = '0;
    logic [2:0]     awprot = '0;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [31:0]    wdata = '0;
    logic [3:0]     wstrb = '0;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready = 1'b0;
    logic [AW-1:0]  araddr = '0;
    logic [2:0]     arprot = '0;
    logic           arvalid = 1'b0;
    logic           arready;
    logic [31:0]    rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready = 1'b0;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]  reg_wr;
    logic [NR-1:0]  reg_rd;

    always #5 aclk = ~aclk;

    axi4l_reg_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .reg_wr(reg_wr), .reg_rd(reg_rd)
    );

    typedef struct packed { logic [1:0] resp; logic [NR-1:0] mask; } exp_b_t;
    typedef struct packed { logic [1:0] resp; logic [31:0] data; logic [NR-1:0] mask; } exp_r_t;

    exp_b_t      exp_b_q[$];
    exp_r_t      exp_r_q[$];
    exp_b_t      cur_b = '0;
    exp_r_t      cur_r = '0;
    logic        prev_bvalid = 1'b0;
    logic        prev_rvalid = 1'b0;
    logic [31:0] model [NR];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no handshake within %0d cycles, required one", name, TMO);
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // Monitor: a response appears on the rising edge of valid and must then stay put.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bvalid && !prev_bvalid) begin
                if (exp_b_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL b_unexpected: bvalid=1, required no response");
                end else begin
                    cur_b = exp_b_q.pop_front();
                    check("bresp", {510'd0, bresp}, {510'd0, cur_b.resp});
                    check("reg_wr", {496'd0, reg_wr}, {496'd0, cur_b.mask});
                end
            end else begin
                check("reg_wr_idle", {496'd0, reg_wr}, '0);
                if (bvalid) check("bresp_hold", {510'd0, bresp}, {510'd0, cur_b.resp});
            end
            if (rvalid && !prev_rvalid) begin
                if (exp_r_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL r_unexpected: rvalid=1, required no response");
                end else begin
                    cur_r = exp_r_q.pop_front();
                    check("rresp", {510'd0, rresp}, {510'd0, cur_r.resp});
                    check("rdata", {480'd0, rdata}, {480'd0, cur_r.data});
                    check("reg_rd", {496'd0, reg_rd}, {496'd0, cur_r.mask});
                end
            end else begin
                check("reg_rd_idle", {496'd0, reg_rd}, '0);
                if (rvalid) begin
                    check("rresp_hold", {510'd0, rresp}, {510'd0, cur_r.resp});
                    check("rdata_hold", {480'd0, rdata}, {480'd0, cur_r.data});
                end
            end
        end
        prev_bvalid = bvalid;
        prev_rvalid = rvalid;
    end

    task automatic send_aw(input logic [AW-1:0] addr, input int dly);
        int n = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        awaddr = addr; awprot = 3'($urandom); awvalid = 1'b1;
        @(negedge aclk);
        while (!awready && n < TMO) begin @(negedge aclk); n++; end
        if (!awready) timeout_fail("aw_handshake");
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        int n = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        @(negedge aclk);
        while (!wready && n < TMO) begin @(negedge aclk); n++; end
        if (!wready) timeout_fail("w_handshake");
        @(posedge aclk); #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] addr, input int dly);
        int n = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && n < TMO) begin @(negedge aclk); n++; end
        if (!arready) timeout_fail("ar_handshake");
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    // Reference model: word index = addr/4, hits below NR, byte-masked update.
    task automatic expect_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int     idx = int'(addr) / 4;
        exp_b_t e;
        e.mask = '0;
        if (idx < NR) begin
            e.resp = OKAY;
            e.mask[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end else begin
            e.resp = DECERR;
        end
        exp_b_q.push_back(e);
    endtask

    task automatic issue_write(input logic [AW-1:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awd, input int wd);
        expect_write(addr, data, strb);
        fork
            send_aw(addr, awd);
            send_w(data, strb, wd);
        join
    endtask

    task automatic issue_read(input logic [AW-1:0] addr, input int dly);
        int     idx = int'(addr) / 4;
        exp_r_t e;
        e.mask = '0;
        if (idx < NR) begin
            e.resp = OKAY;
            e.data = model[idx];
            e.mask[idx] = 1'b1;
        end else begin
            e.resp = DECERR;
            e.data = '0;
        end
        exp_r_q.push_back(e);
        send_ar(addr, dly);
    endtask

    task automatic finish_b(input int dly);
        int n = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        bready = 1'b1;
        @(negedge aclk);
        while (!bvalid && n < TMO) begin @(negedge aclk); n++; end
        if (!bvalid) timeout_fail("b_handshake");
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic finish_r(input int dly);
        int n = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        rready = 1'b1;
        @(negedge aclk);
        while (!rvalid && n < TMO) begin @(negedge aclk); n++; end
        if (!rvalid) timeout_fail("r_handshake");
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        issue_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3));
        finish_b($urandom_range(0, 3));
    endtask

    task automatic do_read(input logic [AW-1:0] addr);
        issue_read(addr, $urandom_range(0, 3));
        finish_r($urandom_range(0, 3));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]    ridx;
        logic [AW-1:0] raddr;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state and ready release
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_readys", {509'd0, awready, wready, arready}, '0);
        check("rst_valids", {510'd0, bvalid, rvalid}, '0);
        check("rst_resp_rdata", {476'd0, bresp, rresp, rdata}, '0);
        check("rst_reg_q", reg_q, '0);
        check("rst_strobes", {480'd0, reg_wr, reg_rd}, '0);
        aresetn = 1'b1;
        #1;
        check("readys_before_edge", {509'd0, awready, wready, arready}, '0);
        @(negedge aclk);
        check("readys_after_edge", {509'd0, awready, wready, arready}, 512'h7);
        @(posedge aclk); #1;

        // Full-word write, AW and W together; best-case turnaround
        issue_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0);
        check("t2_bvalid_n1", {511'd0, bvalid}, 512'h1);
        bready = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        check("t2_n2_ready_bvalid", {509'd0, awready, wready, bvalid}, '0);
        @(negedge aclk);
        check("t2_n3_readys", {510'd0, awready, wready}, 512'h3);
        @(posedge aclk); #1;
        check("t2_reg1", {480'd0, reg_q[63:32]}, 512'hDEADBEEF);
        do_read(12'h004);

        // W ahead of AW, partial strobes
        expect_write(12'h004, 32'h11223344, 4'b0101);
        send_w(32'h11223344, 4'b0101, 0);
        repeat (3) begin
            @(negedge aclk);
            check("t3_w_held", {509'd0, wready, awready, bvalid}, 512'h2);
        end
        @(posedge aclk); #1;
        send_aw(12'h004, 0);
        check("t3_in_resp", {509'd0, wready, awready, bvalid}, 512'h1);
        finish_b(1);
        check("t3_reg1", {480'd0, reg_q[63:32]}, 512'hDE22BE44);
        do_read(12'h005);

        // Out-of-range decode
        do_write(12'h040, 32'hA5A5A5A5, 4'hF);
        do_read(12'h040);
        do_write(12'hFFE, 32'h5A5A5A5A, 4'hF);
        do_read(12'hFFC);
        check("t4_reg_q", reg_q, model_flat());

        // Backpressure on B while reads proceed, then on R while writes proceed
        issue_write(12'h014, 32'h0BADCAFE, 4'hF, 0, 0);
        fork
            repeat (10) begin
                @(negedge aclk);
                check("t5_b_stall", {509'd0, bvalid, awready, wready}, 512'h4);
            end
            do_read(12'h008);
        join
        @(posedge aclk); #1;
        finish_b(0);
        issue_read(12'h014, 0);
        fork
            repeat (10) begin
                @(negedge aclk);
                check("t5_r_stall", {510'd0, rvalid, arready}, 512'h2);
            end
            do_write(12'h01C, 32'h13579BDF, 4'hF);
        join
        @(posedge aclk); #1;
        finish_r(0);
        check("t5_reg_q", reg_q, model_flat());

        // Reset with both paths mid-transaction
        issue_write(12'h00C, 32'h600DF00D, 4'hF, 0, 0);
        issue_read(12'h010, 0);
        #3;
        aresetn = 1'b0;
        #1;
        check("t6_valids", {510'd0, bvalid, rvalid}, '0);
        check("t6_readys", {509'd0, awready, wready, arready}, '0);
        check("t6_reg_q", reg_q, '0);
        exp_b_q.delete();
        exp_r_q.delete();
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        do_write(12'h00C, 32'hCAFEF00D, 4'hF);
        do_read(12'h00C);
        check("t6_reg3", {480'd0, reg_q[127:96]}, 512'hCAFEF00D);

        // Randomized traffic against the model
        for (int k = 0; k < 250; k++) begin
            ridx  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(NR, 1023)) : 10'($urandom_range(0, NR - 1));
            raddr = {ridx, 2'($urandom)};
            if ($urandom_range(0, 1) == 1) do_write(raddr, $urandom, 4'($urandom));
            else                           do_read(raddr);
        end
        check("final_reg_q", reg_q, model_flat());

        repeat (2) @(negedge aclk);
        check("exp_b_drained", 512'(exp_b_q.size()), '0);
        check("exp_r_drained", 512'(exp_r_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
